// File: rtl/custom_instr_pkg.sv
// custom_instr_pkg: shared enums for the custom-instruction coprocessor path
package custom_instr_pkg;
  typedef enum logic [1:0] {
    MODE_SAME  = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_ZEROS = 2'b10,
    MODE_RSVD  = 2'b11
  } run_mode_e;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} run_state_e;
endpackage

// File: rtl/lead_match_cnt.sv
// lead_match_cnt: counts leading window bits (bit 0 first) equal to m within the first w bits
module lead_match_cnt #(
  parameter int CHUNK = 8,
  localparam int CW = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] win_i,
  input  logic [CW-1:0]    w_i,
  input  logic             m_i,
  output logic [CW-1:0]    cnt_o,
  output logic             all_o
);
  logic run;
  always_comb begin
    cnt_o = '0;
    run = 1'b1;
    for (int i = 0; i < CHUNK; i++) begin
      run = run && (i < int'(w_i)) && (win_i[i] == m_i);
      cnt_o = run ? cnt_o + CW'(1) : cnt_o;
    end
  end
  assign all_o = (cnt_o == w_i);
endmodule

// File: rtl/bit_run_counter.sv
// bit_run_counter: multi-cycle run-length counter of equal bits from a start position,
// scanning CHUNK bits per cycle toward the LSB or MSB.
module bit_run_counter
  import custom_instr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] rs0_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [1:0]      mode_i,
  input  logic            dir_i,
  output logic [XLEN-1:0] rd_o,
  output logic            done_o
);
  localparam int PW = $clog2(XLEN);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(CHUNK) + 1;
  run_state_e state_q, state_d;
  logic [XLEN-1:0] data_q, data_d, rd_q, rd_d, rev;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, avail;
  logic [WW-1:0] w, lcnt;
  logic [CHUNK-1:0] win;
  logic dir_q, dir_d, m_q, m_d, all;
  logic unused_rs1;
  assign unused_rs1 = ^rs1_i[XLEN-1:PW];
  for (genvar g = 0; g < XLEN; g++) begin : g_rev
    assign rev[g] = data_q[XLEN-1-g];
  end
  // Downward scans read the bit-reversed operand so the window always starts at bit 0;
  // ~idx equals XLEN-1-idx because XLEN is a power of two.
  assign win = CHUNK'(dir_q ? data_q >> idx_q : rev >> ~idx_q);
  assign avail = dir_q ? CW'(XLEN) - CW'(idx_q) : CW'(idx_q) + CW'(1);
  assign w = (avail < CW'(CHUNK)) ? WW'(avail) : WW'(CHUNK);
  lead_match_cnt #(.CHUNK(CHUNK)) u_lmc (
    .win_i (win),
    .w_i   (w),
    .m_i   (m_q),
    .cnt_o (lcnt),
    .all_o (all)
  );
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    if (state_q == IDLE && start_i) begin
      data_d  = rs0_i;
      idx_d   = rs1_i[PW-1:0];
      dir_d   = dir_i;
      m_d     = (mode_i == MODE_ONES) ? 1'b1 : (mode_i == MODE_ZEROS) ? 1'b0 : rs0_i[rs1_i[PW-1:0]];
      cnt_d   = '0;
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      cnt_d = cnt_q + CW'(lcnt);
      if (all && CW'(w) < avail) begin
        idx_d = dir_q ? idx_q + PW'(w) : idx_q - PW'(w);
      end else begin
        state_d = DONE;
        rd_d    = XLEN'(cnt_d);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end
  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);
  assign rd_o    = rd_q;
endmodule

// File: tb/tb_bit_run_counter.sv
// tb_bit_run_counter: directed checks of the run counter at 32/8 and 64/4 configurations
module tb_bit_run_counter;
  logic clk = 1'b0, rst = 1'b1;
  logic s32 = 1'b0, dir32 = 1'b0, rdy32, done32;
  logic [1:0] md32 = 2'b00;
  logic [31:0] a32 = '0, p32 = '0, rd32;
  logic s64 = 1'b0, dir64 = 1'b0, rdy64, done64;
  logic [1:0] md64 = 2'b00;
  logic [63:0] a64 = '0, p64 = '0, rd64;
  int tests = 0, fails = 0;
  int n;

  always #5 clk = ~clk;

  bit_run_counter #(.XLEN(32), .CHUNK(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(s32), .ready_o(rdy32), .rs0_i(a32), .rs1_i(p32),
    .mode_i(md32), .dir_i(dir32), .rd_o(rd32), .done_o(done32));
  bit_run_counter #(.XLEN(64), .CHUNK(4)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(s64), .ready_o(rdy64), .rs0_i(a64), .rs1_i(p64),
    .mode_i(md64), .dir_i(dir64), .rd_o(rd64), .done_o(done64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge ends cycle 0; returns in cycle 1 with the inputs scrambled.
  task automatic go32(input logic [31:0] d, input int p, input logic dr, input logic [1:0] md);
    a32 = d; p32 = 32'(p); dir32 = dr; md32 = md; s32 = 1'b1;
    tick();
    s32 = 1'b0; a32 = ~d; p32 = 32'h15; dir32 = ~dr; md32 = ~md;
  endtask

  task automatic wait32(input int n0, output int nc);
    nc = n0;
    while (!done32 && nc < 60) begin
      tick();
      nc++;
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] d, input int p, input logic dr,
                       input logic [1:0] md, input int exp_rd, input int exp_k);
    go32(d, p, dr, md);
    check({tag, " busy"}, 64'(rdy32), 64'd0);
    wait32(1, n);
    check({tag, " latency"}, 64'(n), 64'(exp_k + 1));
    check({tag, " rd"}, 64'(rd32), 64'(exp_rd));
    tick();
    check({tag, " ready"}, 64'({rdy32, done32}), 64'b10);
    check({tag, " hold"}, 64'(rd32), 64'(exp_rd));
  endtask

  initial begin
    tick();
    tick();
    check("rst ready32", 64'(rdy32), 64'd1);
    check("rst done32", 64'(done32), 64'd0);
    check("rst rd32", 64'(rd32), 64'd0);
    check("rst ready64", 64'(rdy64), 64'd1);
    check("rst rd64", rd64, 64'd0);
    rst = 1'b0;
    tick();
    run32("half", 32'hFFFF0000, 31, 1'b0, 2'b00, 16, 3);
    run32("ones", 32'hFFFFFFFF, 31, 1'b0, 2'b00, 32, 4);
    run32("trunc dn", 32'h000000F0, 3, 1'b0, 2'b00, 4, 1);
    run32("trunc up", 32'h000000F0, 4, 1'b1, 2'b00, 4, 1);
    run32("lsb same", 32'h00000001, 0, 1'b1, 2'b00, 1, 1);
    run32("lsb zeros", 32'h00000001, 0, 1'b1, 2'b10, 0, 1);
    run32("rsvd", 32'h0000FF00, 8, 1'b1, 2'b11, 8, 2);
    run32("msb edge", 32'hFF000000, 30, 1'b1, 2'b01, 2, 1);
    // start pulses during SCAN must be ignored
    go32(32'hFFFF0000, 31, 1'b0, 2'b00);
    a32 = '0; p32 = '0; md32 = 2'b10; dir32 = 1'b1; s32 = 1'b1;
    tick();
    tick();
    s32 = 1'b0;
    wait32(3, n);
    check("busy latency", 64'(n), 64'd4);
    check("busy rd", 64'(rd32), 64'd16);
    tick();
    tick();
    check("busy no restart", 64'(rdy32), 64'd1);
    // reset mid-SCAN
    go32(32'hFFFFFFFF, 31, 1'b0, 2'b00);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst state", 64'({rdy32, done32}), 64'b10);
    check("mid rst rd", 64'(rd32), 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(done32);
    end
    check("mid rst no done", 64'(n), 64'd0);
    // 64-bit, 4-bit chunk
    a64 = 64'h00FFFFFFFFFFFFFF; p64 = 64'd55; dir64 = 1'b0; md64 = 2'b01; s64 = 1'b1;
    tick();
    s64 = 1'b0; a64 = '0; md64 = 2'b10;
    n = 1;
    while (!done64 && n < 60) begin
      tick();
      n++;
    end
    check("x64 latency", 64'(n), 64'd15);
    check("x64 rd", rd64, 64'd56);
    tick();
    check("x64 ready", 64'({rdy64, done64}), 64'b10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit_run_counter.md
# bit_run_counter

Multi-cycle run-length counter for the custom-instruction coprocessor path. It counts consecutive equal bits in an XLEN-bit operand, starting at a selectable bit position. This is the parametrised successor of the fixed 32-bit, 8-bit-per-cycle bit counter, adding:
- configurable width and scan chunk;
- scan direction and match mode;
- operand capture;
- a ready/start handshake and a held result.

## Interface
- XLEN, 32, operand and result width; power of two, 8..64
- CHUNK, 8, bits examined per scan cycle; power of two, 1 ≤ CHUNK ≤ XLEN
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  request; accepted only when ready_o=1
- ready_o  output  1  high in IDLE only
- rs0_i  input  XLEN  data operand, captured on accept
- rs1_i  input  XLEN  start position; only bits [$clog2(XLEN)-1:0] used, captured on accept
- mode_i  input  2  00 run of bit equal to rs0[pos]; 01 run of ones; 10 run of zeros; 11 reserved, behaves as 00
- dir_i  input  1  0 scan toward LSB (pos downward); 1 scan toward MSB
- rd_o  output  XLEN  run length, zero-extended
- done_o  output  1  one-cycle pulse; rd_o valid from this cycle

## Operation
- **Accept:** start_i && ready_o at a rising edge.
  - Latch rs0, pos, dir and match bit m:
    - mode 00/11: m = rs0[pos];
    - mode 01: m = 1;
    - mode 10: m = 0.
  - Clear count; idx = pos; go to SCAN.
- **SCAN (one window per cycle):**
  - avail = bits from idx to the boundary, inclusive. The boundary is bit 0 for dir=0 and bit XLEN-1 for dir=1.
  - Window w = min(CHUNK, avail) bits, starting at idx and moving in dir.
  - count += number of leading window bits equal to m.
  - If all w bits match and avail > w: idx moves w bits in dir; stay in SCAN.
  - Otherwise go to DONE.
- **DONE:** done_o=1 and rd_o=count for this cycle; next state IDLE.
- **IDLE:** ready_o=1. rd_o holds the last result until the next accept, then holds during SCAN.
- **Result width:** count range is 0..XLEN, needing $clog2(XLEN)+1 bits internally, zero-extended to XLEN.
- **Zero result:** mode 01/10 with rs0[pos] ≠ m gives rd=0 after one scan cycle.
- **Busy:** start_i while not ready_o is ignored, with no queueing. Input changes after accept have no effect.
- **Reset:** rst_i in any state, including mid-SCAN, gives IDLE, count=0, rd_o=0, done_o=0 and ready_o=1 on the following cycle.

## Timing
- Reset values: ready_o=1, done_o=0, rd_o=0.
- Scan cycles k:
  - if the run reaches the boundary: ceil(avail0/CHUNK);
  - otherwise: floor(run/CHUNK)+1.
- With the accept edge in cycle 0, SCAN occupies cycles 1..k and done_o is high in cycle k+1.
- ready_o rises in cycle k+2; the earliest next accept is at the end of cycle k+2.
- Minimum latency is 2 cycles (accept to done_o); maximum is XLEN/CHUNK+1.
- No combinational path from inputs to outputs.

## Structure
- Shared package custom_instr_pkg holds:
  - the run_mode_e enum (MODE_SAME, MODE_ONES, MODE_ZEROS, MODE_RSVD);
  - the FSM state enum (IDLE, SCAN, DONE).
- Sub-module lead_match_cnt is purely combinational. It is parametrised by CHUNK and takes window bits, valid width w and m. It outputs the leading-match count (0..CHUNK) and an all-match flag.
- The top level holds the FSM, operand registers, idx arithmetic (clamped at the boundary) and the count accumulator.

## Test plan
All scenarios use XLEN=32, CHUNK=8 unless stated.
- rs0=0xFFFF0000, pos=31, dir=0, mode=00 → rd=16; k=3; done_o 4 cycles after accept.
- rs0=0xFFFFFFFF, pos=31, dir=0, mode=00 → rd=32; k=4 with boundary stop; done_o in cycle 5.
- rs0=0x000000F0, pos=3, dir=0, mode=00 → rd=4 (window truncated, w=4); k=1. Same operand with pos=4, dir=1 → rd=4.
- rs0=0x00000001, pos=0, dir=1: mode=00 → rd=1; mode=10 → rd=0 after a single scan cycle.
- Busy and reset:
  - start_i pulsed during SCAN with different operands → ignored, first result unchanged;
  - rst_i asserted mid-SCAN → next cycle ready_o=1, done_o=0, rd_o=0, and no done_o pulse follows.
- XLEN=64, CHUNK=4, rs0=0x00FFFFFFFFFFFFFF, pos=55, dir=0, mode=01 → rd=56; k=14; done_o in cycle 15.
